// File: rtl/half_adder_pkg.sv
// Shared types and constants for the half_adder block.
package half_adder_pkg;

  // Default number of independent lanes.
  localparam int DEFAULT_WIDTH = 1;

  // Result of one half-adder lane.
  typedef struct packed {
    logic sum;
    logic carry;
  } lane_result_t;

  // Evaluate a single lane: sum is the XOR, carry is the AND of the two bits.
  function automatic lane_result_t lane_eval(input logic a, input logic b);
    lane_result_t r;
    r.sum   = a ^ b;
    r.carry = a & b;
    return r;
  endfunction

endpackage : half_adder_pkg

// File: rtl/half_adder_ha_cell.sv
// One purely combinational half-adder lane.
module ha_cell
  import half_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  lane_result_t res;

  assign res = lane_eval(a, b);
  assign s   = res.sum;
  assign c   = res.carry;

endmodule : ha_cell

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes with registered outputs.
// Results are captured only on cycles where in_valid is high; otherwise the
// previous result is held and out_valid drops. Every output comes straight
// from a flop, so there is no input-to-output combinational path.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Cout
);

  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] carry_next;
  logic [WIDTH-1:0] y_reg;
  logic [WIDTH-1:0] cout_reg;
  logic             valid_reg;

  // One cell per lane; lanes never share a carry.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
      ha_cell u_cell (
        .a (A[gi]),
        .b (B[gi]),
        .s (sum_next[gi]),
        .c (carry_next[gi])
      );
    end
  endgenerate

  // Output/valid registers: capture on accepted cycles, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      y_reg     <= '0;
      cout_reg  <= '0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        y_reg    <= sum_next;
        cout_reg <= carry_next;
      end
    end
  end

  assign out_valid = valid_reg;
  assign Y         = y_reg;
  assign Cout      = cout_reg;

endmodule : half_adder

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: one 1-lane and one 4-lane instance
// driven side by side, checked against an arithmetic reference model.
module tb_half_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ov1, ov4;
  logic [0:0] y1, c1;
  logic [3:0] y4, c4;

  int n_cmp = 0;
  int n_err = 0;

  // Expected held state of the 4-lane instance.
  logic [3:0] exp_y4, exp_c4;

  half_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(a1), .B(b1), .out_valid(ov1), .Y(y1), .Cout(c1)
  );

  half_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(a4), .B(b4), .out_valid(ov4), .Y(y4), .Cout(c4)
  );

  always #5 clk = ~clk;

  // Reference: per lane, add the two bits as integers; the sum bit is the
  // remainder mod 2 and the carry is whether the total reached 2.
  function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] s;
    logic [3:0] c;
    for (int i = 0; i < 4; i++) begin
      int t;
      t = (a[i] ? 1 : 0) + (b[i] ? 1 : 0);
      s[i] = ((t % 2) == 1);
      c[i] = (t >= 2);
    end
    return {s, c};
  endfunction

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a1 = 1'b1; b1 = 1'b1;
    a4 = 4'($urandom); b4 = 4'($urandom);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    $display("reset: w1 v=%b y=%b c=%b | w4 v=%b y=%h c=%h", ov1, y1, c1, ov4, y4, c4);
    if ({ov1, y1, c1, ov4, y4, c4} !== 12'd0) begin
      n_err++;
      $display("FAIL reset_state: got %b required 0", {ov1, y1, c1, ov4, y4, c4});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_y4 = '0;
    exp_c4 = '0;
  endtask

  task automatic test_first_capture();
    logic [7:0] e;
    in_valid = 1'b1;
    a4 = 4'($urandom); b4 = 4'($urandom);
    e = model4(a4, b4);
    @(posedge clk); #1;
    n_cmp++;
    $display("first_capture: a=%h b=%h -> v=%b y=%h c=%h", a4, b4, ov4, y4, c4);
    if ({ov4, y4, c4} !== {1'b1, e}) begin
      n_err++;
      $display("FAIL first_capture: got %b required %b", {ov4, y4, c4}, {1'b1, e});
    end
    exp_y4 = e[7:4]; exp_c4 = e[3:0];
  endtask

  task automatic test_truth_table();
    logic [1:0] k;
    logic [7:0] e;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      k = 2'(i);
      a1 = k[1]; b1 = k[0];
      e = model4({3'b0, a1}, {3'b0, b1});
      @(posedge clk); #1;
      n_cmp++;
      $display("truth_table: a=%b b=%b -> v=%b y=%b c=%b", a1, b1, ov1, y1, c1);
      if ({ov1, y1, c1} !== {1'b1, e[4], e[0]}) begin
        n_err++;
        $display("FAIL truth_table_%0d: got %b required %b", i, {ov1, y1, c1}, {1'b1, e[4], e[0]});
      end
    end
  endtask

  task automatic test_vector();
    in_valid = 1'b1;
    a4 = 4'b1010; b4 = 4'b0110;
    @(posedge clk); #1;
    n_cmp++;
    $display("vector: a=%b b=%b -> v=%b y=%b c=%b", a4, b4, ov4, y4, c4);
    if ({ov4, y4, c4} !== {1'b1, 4'b1100, 4'b0010}) begin
      n_err++;
      $display("FAIL vector_1010_0110: got %b required %b", {ov4, y4, c4}, {1'b1, 4'b1100, 4'b0010});
    end
    exp_y4 = 4'b1100; exp_c4 = 4'b0010;
  endtask

  task automatic test_hold();
    in_valid = 1'b1;
    a1 = 1'b1; b1 = 1'b1;
    a4 = 4'b1011; b4 = 4'b0011;
    @(posedge clk); #1;
    exp_y4 = 4'b1000; exp_c4 = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b0;
      a1 = 1'b0; b1 = 1'b0;
      if (i == 2) begin
        a4 = 4'bx01z; b4 = 4'bzx10;
      end else begin
        a4 = 4'($urandom); b4 = 4'($urandom);
      end
      @(posedge clk); #1;
      n_cmp++;
      $display("hold_%0d: w1 v=%b y=%b c=%b | w4 v=%b y=%h c=%h", i, ov1, y1, c1, ov4, y4, c4);
      if ({ov1, y1, c1, ov4, y4, c4} !== {1'b0, 1'b0, 1'b1, 1'b0, exp_y4, exp_c4}) begin
        n_err++;
        $display("FAIL hold_%0d: got %b required %b", i, {ov1, y1, c1, ov4, y4, c4},
                 {1'b0, 1'b0, 1'b1, 1'b0, exp_y4, exp_c4});
      end
    end
    a4 = '0; b4 = '0;
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    a1 = 1'b1; b1 = 1'b0;
    a4 = 4'b1111; b4 = 4'b0000;
    @(posedge clk); #1;
    n_cmp++;
    $display("async_pre: v=%b y=%b c=%b", ov1, y1, c1);
    if ({ov1, y1, c1} !== 3'b110) begin
      n_err++;
      $display("FAIL async_pre: got %b required 110", {ov1, y1, c1});
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    $display("async_mid: w1 v=%b y=%b c=%b | w4 v=%b y=%h c=%h", ov1, y1, c1, ov4, y4, c4);
    if ({ov1, y1, c1, ov4, y4, c4} !== 12'd0) begin
      n_err++;
      $display("FAIL async_clear: got %b required 0", {ov1, y1, c1, ov4, y4, c4});
    end
    a1 = 1'b1; b1 = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    $display("async_held: w1 v=%b y=%b c=%b | w4 v=%b y=%h c=%h", ov1, y1, c1, ov4, y4, c4);
    if ({ov1, y1, c1, ov4, y4, c4} !== 12'd0) begin
      n_err++;
      $display("FAIL async_discard: got %b required 0", {ov1, y1, c1, ov4, y4, c4});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_y4 = '0; exp_c4 = '0;
  endtask

  task automatic test_exhaustive();
    logic [7:0] p;
    logic [7:0] e;
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      p = 8'(i);
      a4 = p[7:4]; b4 = p[3:0];
      e = model4(a4, b4);
      @(posedge clk); #1;
      n_cmp++;
      $display("exhaustive: a=%h b=%h -> v=%b y=%h c=%h", a4, b4, ov4, y4, c4);
      if ({ov4, y4, c4} !== {1'b1, e}) begin
        n_err++;
        $display("FAIL exhaustive_%0d: got %b required %b", i, {ov4, y4, c4}, {1'b1, e});
      end
      exp_y4 = e[7:4]; exp_c4 = e[3:0];
    end
  endtask

  task automatic test_back_to_back_random();
    logic [7:0] e;
    logic       v;
    for (int i = 0; i < 200; i++) begin
      v = 1'($urandom);
      in_valid = v;
      a4 = 4'($urandom); b4 = 4'($urandom);
      if (v) begin
        e = model4(a4, b4);
        exp_y4 = e[7:4]; exp_c4 = e[3:0];
      end
      @(posedge clk); #1;
      n_cmp++;
      $display("random: iv=%b a=%h b=%h -> v=%b y=%h c=%h", v, a4, b4, ov4, y4, c4);
      if ({ov4, y4, c4} !== {v, exp_y4, exp_c4}) begin
        n_err++;
        $display("FAIL random_%0d: got %b required %b", i, {ov4, y4, c4}, {v, exp_y4, exp_c4});
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_capture();
    test_truth_table();
    test_vector();
    test_hold();
    test_async_reset();
    test_first_capture();
    test_exhaustive();
    test_back_to_back_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_half_adder
